carry_select_serial_subtractor: RTL and testbench
=================================================

// Module: carry_select_serial_subtractor
// PURPOSE
// - Multi-cycle signed subtractor: Diff = A - B - Bin, processed CHUNK bits per cycle, LSB chunk first.
// - Each chunk computes A + ~B twice, with carry-in 0 and carry-in 1; the running carry selects one result.
// - Valid/ready on input and output, so a datapath FSM can stream operand pairs through it.
// - Subtract-side companion to the 32-bit carry-select adder; same width, same overflow semantics.
// PARAMETERS
// - N      32  operand/result width; must be a multiple of CHUNK
// - CHUNK  4   bits resolved per RUN cycle; NCH = N/CHUNK cycles per operation
// PORTS
// - clk        in   1  single clock; all state updates on rising edge
// - rst        in   1  synchronous, active-high reset
// - in_valid   in   1  operands A, B, Bin are valid
// - in_ready   out  1  block can accept operands (high only in IDLE)
// - A          in   N  signed minuend
// - B          in   N  signed subtrahend
// - Bin        in   1  borrow-in
// - out_valid  out  1  Diff, Bout, Overflow are valid (high only in DONE)
// - out_ready  in   1  consumer accepts the result
// - Diff       out  N  signed difference
// - Bout       out  1  unsigned borrow-out (1 when A < B + Bin, unsigned)
// - Overflow   out  1  signed overflow of the subtraction
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1; out_valid=0; Diff=0; Bout=0; Overflow=0; chunk index=0.
// - FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE->RUN on in_valid&&in_ready. Capture A, B, and ~B; set carry=~Bin; set idx=0.
//   - RUN processes chunk idx each cycle:
//     - s0 = A_c + ~B_c + 0 and s1 = A_c + ~B_c + 1, each CHUNK+1 bits.
//     - Select s1 if carry=1, else s0; write the selected sum bits to Diff[idx*CHUNK +: CHUNK].
//     - carry <= selected MSB; idx <= idx+1.
//   - RUN->DONE after chunk NCH-1. In the same edge:
//     - Bout = ~final carry.
//     - Overflow = (A[N-1]!=B[N-1]) && (Diff[N-1]!=A[N-1]).
//   - DONE->IDLE on out_valid&&out_ready. in_ready rises on the following cycle; no back-to-back accept.
// - Latency: accept at edge T; out_valid=1 from edge T+NCH (32/4: 8 cycles). Throughput is one op per NCH+2 cycles.
// - Outputs are held stable in DONE while out_ready=0. Diff is not guaranteed meaningful outside DONE.
// - in_valid is ignored in RUN and DONE, and operand inputs are not sampled there.
// - Unsigned wrap: Diff is the result mod 2^N. 0 - 1 gives all-ones with Bout=1.
// - Reset mid-RUN or mid-DONE: the operation is discarded; all outputs and the FSM return to reset values next cycle.
// - rst has priority over every handshake.
// CONFIGURATION
// - SUB_SATURATE_EN defined: when Overflow=1, Diff is clamped in the DONE-entry edge.
//   - A[N-1]=0 clamps to 2^(N-1)-1.
//   - A[N-1]=1 clamps to -2^(N-1).
//   - Overflow still reports 1.
// - SUB_SATURATE_EN undefined: Diff is the wrapped two's-complement result; no clamp logic is instantiated.
// TESTING (N=32, CHUNK=4)
// - A=5, B=3, Bin=0 -> Diff=0x00000002, Bout=0, Overflow=0; out_valid exactly 8 cycles after the accept edge.
// - A=3, B=5, Bin=0 -> Diff=0xFFFFFFFE, Bout=1, Overflow=0.
// - A=0, B=0, Bin=1 -> Diff=0xFFFFFFFF, Bout=1, Overflow=0.
// - A=0x80000000, B=1 -> Overflow=1, Bout=0.
//   - Diff=0x7FFFFFFF without SUB_SATURATE_EN.
//   - Diff=0x80000000 with SUB_SATURATE_EN.
// - out_ready=0 for 5 cycles in DONE -> Diff, Bout, Overflow, out_valid stable; in_ready=0; new in_valid ignored.
// - rst=1 on the 4th RUN cycle -> next cycle: IDLE, in_ready=1, out_valid=0, Diff=0.
//   - A fresh op 7-9 then yields Diff=0xFFFFFFFE, Bout=1.

Source files
------------

// File: rtl/carry_select_serial_subtractor.sv
// Multi-cycle signed subtractor Diff = A - B - Bin, CHUNK bits per cycle, LSB first.
// Optional macro SUB_SATURATE_EN clamps Diff on signed overflow.
module carry_select_serial_subtractor #(
   parameter int N     = 32,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Diff,
   output logic         Bout,
   output logic         Overflow,
   output logic [1:0]   dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its outputs until out_ready.
   localparam int NCH = N / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [N-1:0]      a_q;
   logic [N-1:0]      nb_q;
   logic              b_sign;
   logic              carry;
   logic [IW-1:0]     idx;

   logic [CHUNK-1:0]  a_c;
   logic [CHUNK-1:0]  nb_c;
   logic [CHUNK:0]    s0;
   logic [CHUNK:0]    s1;
   logic [CHUNK:0]    sel;
   logic [N-1:0]      diff_next;
   logic              ovf_next;
   logic              last;

   assign dbg_state = state;

   always_comb begin
      a_c       = a_q[idx*CHUNK +: CHUNK];
      nb_c      = nb_q[idx*CHUNK +: CHUNK];
      s0        = {1'b0, a_c} + {1'b0, nb_c};
      s1        = s0 + {{CHUNK{1'b0}}, 1'b1};
      sel       = carry ? s1 : s0;
      last      = (idx == IW'(NCH - 1));
      diff_next = Diff;
      diff_next[idx*CHUNK +: CHUNK] = sel[CHUNK-1:0];
      // Only meaningful on the last chunk, when diff_next holds the full result.
      ovf_next  = (a_q[N-1] != b_sign) && (diff_next[N-1] != a_q[N-1]);
`ifdef SUB_SATURATE_EN
      if (last && ovf_next)
         diff_next = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Diff      <= '0;
         Bout      <= 1'b0;
         Overflow  <= 1'b0;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         nb_q      <= '0;
         b_sign    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= A;
                  nb_q     <= ~B;
                  b_sign   <= B[N-1];
                  carry    <= ~Bin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               Diff  <= diff_next;
               carry <= sel[CHUNK];
               idx   <= idx + 1'b1;
               if (last) begin
                  Bout      <= ~sel[CHUNK];
                  Overflow  <= ovf_next;
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_carry_select_serial_subtractor.sv
// Directed bench for carry_select_serial_subtractor (N=32, CHUNK=4); honours SUB_SATURATE_EN.
module tb_carry_select_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Diff;
   logic        Bout;
   logic        Overflow;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   carry_select_serial_subtractor #(.N(32), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .Diff(Diff), .Bout(Bout), .Overflow(Overflow), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   // Driver tasks
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
      @(negedge clk);
      A = a; B = b; Bin = bin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (Diff !== 32'h0) begin n_fail++; $display("FAIL reset_diff got %h want 0", Diff); end
      n_checks++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got %b want 0", Bout); end
      n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", Overflow); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [31:0] va[6];
      logic [31:0] vb[6];
      logic        vbin[6];
      logic        ebout[6];
      logic        eovf[6];
      logic [31:0] exp_d;
      int lat;
      va[0] = 32'd5;          vb[0] = 32'd3;          vbin[0] = 0; ebout[0] = 0; eovf[0] = 0;
      va[1] = 32'd3;          vb[1] = 32'd5;          vbin[1] = 0; ebout[1] = 1; eovf[1] = 0;
      va[2] = 32'd0;          vb[2] = 32'd0;          vbin[2] = 1; ebout[2] = 1; eovf[2] = 0;
      va[3] = 32'h80000000;   vb[3] = 32'd1;          vbin[3] = 0; ebout[3] = 0; eovf[3] = 1;
      va[4] = 32'h7FFFFFFF;   vb[4] = 32'hFFFFFFFF;   vbin[4] = 0; ebout[4] = 1; eovf[4] = 1;
      va[5] = 32'h12345678;   vb[5] = 32'h02345679;   vbin[5] = 1; ebout[5] = 0; eovf[5] = 0;
      exp_q.push_back(32'h00000002);
      exp_q.push_back(32'hFFFFFFFE);
      exp_q.push_back(32'hFFFFFFFF);
`ifdef SUB_SATURATE_EN
      exp_q.push_back(32'h80000000);
      exp_q.push_back(32'h7FFFFFFF);
`else
      exp_q.push_back(32'h7FFFFFFF);
      exp_q.push_back(32'h80000000);
`endif
      exp_q.push_back(32'h0FFFFFFE);
      for (int i = 0; i < 6; i++) begin
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); end
         start_op(va[i], vb[i], vbin[i]);
         wait_done(lat);
         exp_d = exp_q.pop_front();
         n_checks++; if (lat != 8) begin n_fail++; $display("FAIL vec%0d_latency got %0d want 8", i, lat); end
         n_checks++; if (Diff !== exp_d) begin n_fail++; $display("FAIL vec%0d_diff got %h want %h", i, Diff, exp_d); end
         n_checks++; if (Bout !== ebout[i]) begin n_fail++; $display("FAIL vec%0d_bout got %b want %b", i, Bout, ebout[i]); end
         n_checks++; if (Overflow !== eovf[i]) begin n_fail++; $display("FAIL vec%0d_ovf got %b want %b", i, Overflow, eovf[i]); end
         release_result();
      end
   endtask

   task automatic test_hold();
      int lat;
      start_op(32'd3, 32'd5, 1'b0);
      wait_done(lat);
      @(negedge clk);
      A = 32'd100; B = 32'd1; Bin = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d_out_valid got %b want 1", c, out_valid); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_in_ready got %b want 0", c, in_ready); end
         n_checks++; if (Diff !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL hold%0d_diff got %h want fffffffe", c, Diff); end
         n_checks++; if (Bout !== 1'b1) begin n_fail++; $display("FAIL hold%0d_bout got %b want 1", c, Bout); end
         n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL hold%0d_ovf got %b want 0", c, Overflow); end
      end
      in_valid = 1'b0;
      release_result();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid got %b want 0", out_valid); end
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL hold_release_state got %0d want 0", dbg_state); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      start_op(32'h12345678, 32'h11111111, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrun_state got %0d want 0", dbg_state); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_out_valid got %b want 0", out_valid); end
      n_checks++; if (Diff !== 32'h0) begin n_fail++; $display("FAIL midrun_diff got %h want 0", Diff); end
      @(negedge clk);
      rst = 1'b0;
      start_op(32'd7, 32'd9, 1'b0);
      wait_done(lat);
      n_checks++; if (lat != 8) begin n_fail++; $display("FAIL after_rst_latency got %0d want 8", lat); end
      n_checks++; if (Diff !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL after_rst_diff got %h want fffffffe", Diff); end
      n_checks++; if (Bout !== 1'b1) begin n_fail++; $display("FAIL after_rst_bout got %b want 1", Bout); end
      release_result();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Bin = 1'b0;
      test_reset();
      test_vectors();
      test_hold();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
